// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared widths, dither mode encoding and 4x4 Bayer threshold
//               matrix for the VGA RGB444 -> RGB222 output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int C_CHAN_IN_W  = 4;
    localparam int C_CHAN_OUT_W = 2;

    typedef enum logic [1:0] {
        TRUNC    = 2'd0,
        ORDERED  = 2'd1,
        TEMPORAL = 2'd2,
        BLANK    = 2'd3
    } mode_e;

    // Flattened Bayer matrix, entry index = {yi, xi}; entry 0 sits at the LSB.
    // Rows: {0,8,2,10} {12,4,14,6} {3,11,1,9} {15,7,13,5}
    localparam logic [15:0][3:0] C_BAYER = {
        4'd5,  4'd13, 4'd7,  4'd15,
        4'd9,  4'd1,  4'd11, 4'd3,
        4'd6,  4'd14, 4'd4,  4'd12,
        4'd10, 4'd2,  4'd8,  4'd0
    };

    function automatic logic [3:0] bayer_threshold(input logic [1:0] xi,
                                                   input logic [1:0] yi);
        return C_BAYER[{yi, xi}];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_dither_out_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_dither_out_if
// Description : Video timing + pixel bundle into the dither stage and the
//               delayed PMOD-side outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_dither_out_if;
    import vga_pkg::*;

    logic                    hsync_in;
    logic                    vsync_in;
    logic                    visible_in;
    logic [9:0]              position_x;
    logic [8:0]              position_y;
    logic [31:0]             frame;
    logic [C_CHAN_IN_W-1:0]  r_in;
    logic [C_CHAN_IN_W-1:0]  g_in;
    logic [C_CHAN_IN_W-1:0]  b_in;
    logic [1:0]              mode;

    logic                    hsync;
    logic                    vsync;
    logic                    visible;
    logic [C_CHAN_OUT_W-1:0] r;
    logic [C_CHAN_OUT_W-1:0] g;
    logic [C_CHAN_OUT_W-1:0] b;

    modport master (
        output hsync_in, vsync_in, visible_in, position_x, position_y, frame,
               r_in, g_in, b_in, mode,
        input  hsync, vsync, visible, r, g, b
    );

    modport slave (
        input  hsync_in, vsync_in, visible_in, position_x, position_y, frame,
               r_in, g_in, b_in, mode,
        output hsync, vsync, visible, r, g, b
    );

endinterface
`default_nettype wire

// File: rtl/dither_quant.sv
`default_nettype none
// ============================================================================
// Module      : dither_quant
// Description : Combinational single-channel 4-bit -> 2-bit ordered-dither
//               quantizer against a 4-bit threshold.
// Revision    : 1.0 - initial release
// ============================================================================
module dither_quant
    import vga_pkg::*;
(
    input  wire logic [C_CHAN_IN_W-1:0]  i_v,
    input  wire logic [3:0]              i_t,
    output logic      [C_CHAN_OUT_W-1:0] o_q
);

    logic [5:0] w_scaled;
    logic [2:0] w_sum;

    // 3*v + v/4 maps 0..15 onto 0..48 so that q occupies bits [5:4] exactly.
    assign w_scaled = {2'b00, i_v} + {1'b0, i_v, 1'b0} + {4'b0000, i_v[3:2]};

    assign w_sum = {1'b0, w_scaled[5:4]} + {2'b00, (w_scaled[3:0] > i_t)};

    assign o_q = w_sum[2] ? 2'd3 : w_sum[1:0];

endmodule
`default_nettype wire

// File: rtl/vga_dither_out.sv
`default_nettype none
// ============================================================================
// Module      : vga_dither_out
// Description : Two-stage RGB444 -> RGB222 output stage with truncate,
//               ordered, temporal-ordered and blank modes; syncs realigned.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_dither_out
    import vga_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vga_dither_out_if.slave  vid
);

    // ------------------------------------------------------------------
    // Frame-synchronous mode register
    // ------------------------------------------------------------------
    mode_e r_mode_q;
    logic  r_vsync_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q     <= TRUNC;
            r_vsync_prev <= 1'b1;
        end else begin
            r_vsync_prev <= vid.vsync_in;
            if (vid.vsync_in && !r_vsync_prev) begin
                r_mode_q <= mode_e'(vid.mode);
            end
        end
    end

    // ------------------------------------------------------------------
    // Threshold lookup for the pixel entering stage 1
    // ------------------------------------------------------------------
    logic [1:0] w_offset;
    logic [1:0] w_xi;
    logic [1:0] w_yi;
    logic [3:0] w_thresh;
    logic       w_unused_bits;

    assign w_offset = (r_mode_q == TEMPORAL) ? vid.frame[1:0] : 2'd0;
    assign w_xi     = vid.position_x[1:0] + w_offset;
    assign w_yi     = vid.position_y[1:0] + w_offset;
    assign w_thresh = bayer_threshold(w_xi, w_yi);

    assign w_unused_bits = ^{vid.frame[31:2], vid.position_x[9:2],
                             vid.position_y[8:2]};

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic                   r_s1_hsync;
    logic                   r_s1_vsync;
    logic                   r_s1_visible;
    logic [C_CHAN_IN_W-1:0] r_s1_r;
    logic [C_CHAN_IN_W-1:0] r_s1_g;
    logic [C_CHAN_IN_W-1:0] r_s1_b;
    logic [3:0]             r_s1_t;
    mode_e                  r_s1_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hsync   <= 1'b1;
            r_s1_vsync   <= 1'b1;
            r_s1_visible <= 1'b0;
            r_s1_r       <= '0;
            r_s1_g       <= '0;
            r_s1_b       <= '0;
            r_s1_t       <= '0;
            r_s1_mode    <= TRUNC;
        end else begin
            r_s1_hsync   <= vid.hsync_in;
            r_s1_vsync   <= vid.vsync_in;
            r_s1_visible <= vid.visible_in;
            r_s1_r       <= vid.r_in;
            r_s1_g       <= vid.g_in;
            r_s1_b       <= vid.b_in;
            r_s1_t       <= w_thresh;
            r_s1_mode    <= r_mode_q;
        end
    end

    // ------------------------------------------------------------------
    // Quantization between stage 1 and stage 2
    // ------------------------------------------------------------------
    logic [C_CHAN_OUT_W-1:0] w_dq_r;
    logic [C_CHAN_OUT_W-1:0] w_dq_g;
    logic [C_CHAN_OUT_W-1:0] w_dq_b;

    dither_quant u_quant_r (.i_v(r_s1_r), .i_t(r_s1_t), .o_q(w_dq_r));
    dither_quant u_quant_g (.i_v(r_s1_g), .i_t(r_s1_t), .o_q(w_dq_g));
    dither_quant u_quant_b (.i_v(r_s1_b), .i_t(r_s1_t), .o_q(w_dq_b));

    logic [C_CHAN_OUT_W-1:0] w_sel_r;
    logic [C_CHAN_OUT_W-1:0] w_sel_g;
    logic [C_CHAN_OUT_W-1:0] w_sel_b;

    always_comb begin
        w_sel_r = '0;
        w_sel_g = '0;
        w_sel_b = '0;
        // Blanking outside the active area overrides every mode.
        if (r_s1_visible) begin
            case (r_s1_mode)
                TRUNC: begin
                    w_sel_r = r_s1_r[3:2];
                    w_sel_g = r_s1_g[3:2];
                    w_sel_b = r_s1_b[3:2];
                end
                ORDERED, TEMPORAL: begin
                    w_sel_r = w_dq_r;
                    w_sel_g = w_dq_g;
                    w_sel_b = w_dq_b;
                end
                default: begin
                    w_sel_r = '0;
                    w_sel_g = '0;
                    w_sel_b = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    logic                    r_s2_hsync;
    logic                    r_s2_vsync;
    logic                    r_s2_visible;
    logic [C_CHAN_OUT_W-1:0] r_s2_r;
    logic [C_CHAN_OUT_W-1:0] r_s2_g;
    logic [C_CHAN_OUT_W-1:0] r_s2_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_hsync   <= 1'b1;
            r_s2_vsync   <= 1'b1;
            r_s2_visible <= 1'b0;
            r_s2_r       <= '0;
            r_s2_g       <= '0;
            r_s2_b       <= '0;
        end else begin
            r_s2_hsync   <= r_s1_hsync;
            r_s2_vsync   <= r_s1_vsync;
            r_s2_visible <= r_s1_visible;
            r_s2_r       <= w_sel_r;
            r_s2_g       <= w_sel_g;
            r_s2_b       <= w_sel_b;
        end
    end

    // Only the two-stage pipeline is implemented; other depths park the
    // outputs at their idle levels.
    generate
        if (LATENCY == 2) begin : g_lat2
            assign vid.hsync   = r_s2_hsync;
            assign vid.vsync   = r_s2_vsync;
            assign vid.visible = r_s2_visible;
            assign vid.r       = r_s2_r;
            assign vid.g       = r_s2_g;
            assign vid.b       = r_s2_b;
        end else begin : g_lat_unsupported
            assign vid.hsync   = 1'b1;
            assign vid.vsync   = 1'b1;
            assign vid.visible = 1'b0;
            assign vid.r       = '0;
            assign vid.g       = '0;
            assign vid.b       = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_dither_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_dither_out
// Description : Self-checking bench for vga_dither_out: directed scenarios
//               plus randomized traffic against a per-pixel reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_dither_out;

    localparam logic [8:0] C_RST_OUT = 9'h180; // {hsync,vsync,visible,r,g,b}
    localparam int         C_DEPTH   = 4096;

    logic clk = 1'b0;
    logic rst;

    always #20 clk = ~clk;

    vga_dither_out_if vif ();

    vga_dither_out #(.LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .vid (vif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [8:0] exp_q [0:C_DEPTH-1];
    bit         lit_v [0:C_DEPTH-1];
    logic [5:0] lit_q [0:C_DEPTH-1];

    // Drive state applied on every step
    logic        d_rst, d_hs, d_vs, d_vis;
    logic [31:0] d_frame;
    logic [1:0]  d_mode;

    // Model state: active mode and previous vsync_in
    int m_mode;
    bit m_prev;

    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [1:0] chan(input int v, input int t, input int md);
        int s, q;
        if (md == 0) return 2'(v / 4);
        if (md == 3) return 2'd0;
        s = 3 * v + v / 4;
        q = s / 16 + (((s % 16) > t) ? 1 : 0);
        return 2'((q > 3) ? 3 : q);
    endfunction

    task automatic step(input int x, input int y, input int rv, input int gv, input int bv,
                        input bit lv, input logic [5:0] lr);
        int o, t;
        logic [5:0] rgb;
        @(negedge clk);
        if (cyc >= 2) begin
            check("out", {vif.hsync, vif.vsync, vif.visible, vif.r, vif.g, vif.b}, exp_q[cyc-2]);
            if (lit_v[cyc-2])
                check("rgb_fixed", {3'b000, vif.r, vif.g, vif.b}, {3'b000, lit_q[cyc-2]});
        end
        rst            = d_rst;
        vif.hsync_in   = d_hs;
        vif.vsync_in   = d_vs;
        vif.visible_in = d_vis;
        vif.position_x = 10'(x);
        vif.position_y = 9'(y);
        vif.frame      = d_frame;
        vif.r_in       = 4'(rv);
        vif.g_in       = 4'(gv);
        vif.b_in       = 4'(bv);
        vif.mode       = d_mode;
        lit_v[cyc] = lv;
        lit_q[cyc] = lr;
        if (d_rst) begin
            exp_q[cyc] = C_RST_OUT;
            lit_v[cyc] = 1'b0;
            if (cyc > 0) begin
                exp_q[cyc-1] = C_RST_OUT;
                lit_v[cyc-1] = 1'b0;
            end
            m_mode = 0;
            m_prev = 1'b1;
        end else begin
            o = (m_mode == 2) ? int'(d_frame[1:0]) : 0;
            t = bayer[((y % 4) + o) % 4][((x % 4) + o) % 4];
            rgb = d_vis ? {chan(rv, t, m_mode), chan(gv, t, m_mode), chan(bv, t, m_mode)} : 6'd0;
            exp_q[cyc] = {d_hs, d_vs, d_vis, rgb};
            if (d_vs && !m_prev) m_mode = int'(d_mode);
            m_prev = d_vs;
        end
        cyc++;
    endtask

    // vsync_in low then high; the mode presented on the rising cycle is captured.
    task automatic vsync_pulse(input logic [1:0] md);
        d_mode = md;
        d_vs = 1'b0;
        step(0, 0, 0, 0, 0, 1'b0, 6'd0);
        d_vs = 1'b1;
        step(0, 0, 0, 0, 0, 1'b0, 6'd0);
    endtask

    initial begin
        d_rst = 1'b1; d_hs = 1'b1; d_vs = 1'b1; d_vis = 1'b0;
        d_frame = '0; d_mode = 2'd0;
        m_mode = 0; m_prev = 1'b1;
        rst = 1'b1;
        vif.hsync_in = 1'b1; vif.vsync_in = 1'b1; vif.visible_in = 1'b0;
        vif.position_x = '0; vif.position_y = '0; vif.frame = '0;
        vif.r_in = '0; vif.g_in = '0; vif.b_in = '0; vif.mode = '0;

        repeat (3) step(0, 0, 9, 9, 9, 1'b0, 6'd0);
        d_rst = 1'b0;

        // Ordered dither
        vsync_pulse(2'd1);
        d_vis = 1'b1;
        step(0, 0, 8, 0, 0, 1'b1, {2'd2, 4'd0});
        step(0, 3, 8, 0, 0, 1'b1, {2'd1, 4'd0});
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                step(x, y, 15, 15, 15, 1'b1, 6'h3f);
        for (int x = 0; x < 4; x++)
            step(x, 2, 0, 0, 0, 1'b1, 6'd0);
        d_vis = 1'b0;
        step(1, 1, 15, 0, 0, 1'b1, 6'd0);
        d_vis = 1'b1;

        // Truncate
        vsync_pulse(2'd0);
        step(2, 1, 8, 0, 0, 1'b1, {2'd2, 4'd0});

        // Temporal: frame 1, x=3, y=0 -> t=12
        vsync_pulse(2'd2);
        d_frame = 32'd1;
        step(3, 0, 0, 8, 0, 1'b1, {2'd0, 2'd1, 2'd0});

        // Mid-frame mode request must wait for vsync rising edge
        vsync_pulse(2'd0);
        d_mode = 2'd3;
        for (int i = 0; i < 4; i++) begin
            d_hs = i[0];
            step(i, 0, 8, 0, 0, 1'b1, {2'd2, 4'd0});
        end
        vsync_pulse(2'd3);
        for (int i = 0; i < 6; i++) begin
            d_hs = i[0];
            step(i, 1, 15, 15, 15, 1'b1, 6'd0);
        end
        d_hs = 1'b1;

        // Reset mid-line
        d_mode = 2'd0;
        step(5, 5, 4, 4, 4, 1'b0, 6'd0);
        d_rst = 1'b1;
        step(6, 5, 4, 4, 4, 1'b0, 6'd0);
        d_rst = 1'b0;
        step(7, 5, 15, 15, 15, 1'b1, 6'h3f);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) d_vs = ~d_vs;
            if ($urandom_range(0, 7) == 0)  d_hs = ~d_hs;
            d_vis   = ($urandom_range(0, 4) != 0);
            d_mode  = 2'($urandom_range(0, 3));
            d_frame = $urandom;
            d_rst   = ($urandom_range(0, 149) == 0);
            step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 1'b0, 6'd0);
        end
        d_rst = 1'b0;
        repeat (3) step(0, 0, 0, 0, 0, 1'b0, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_dither_out.md
VGA_DITHER_OUT -- requirements
Module: vga_dither_out

Interface
REQ-001 Parameter LATENCY, default 2, pipeline depth from inputs to outputs; fixed at 2, other values unsupported.
REQ-002 clk  input  1  pixel clock (25.175 MHz).
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 hsync_in, vsync_in  input  1 each  active-low syncs from the video timer.
REQ-005 visible_in  input  1  high inside the 640x480 active area.
REQ-006 position_x  input  10  current pixel column, aligned with r_in/g_in/b_in.
REQ-007 position_y  input  9  current pixel row, aligned with r_in/g_in/b_in.
REQ-008 frame  input  32  frame counter from the timer; only bits [1:0] are used.
REQ-009 r_in, g_in, b_in  input  4 each  RGB444 pixel from the image generator.
REQ-010 mode  input  2  0 = truncate, 1 = ordered dither, 2 = ordered plus temporal dither, 3 = blank.
REQ-011 hsync, vsync  output  1 each  delayed syncs to the PMOD.
REQ-012 r, g, b  output  2 each  RGB222 pixel to the PMOD.
REQ-013 visible  output  1  delayed visible_in.

Function
REQ-014 All outputs SHALL appear exactly 2 cycles after the inputs that produced them; syncs, visible and RGB stay mutually aligned.
REQ-015 Stage 1 SHALL register the syncs, visible_in, RGB, and the 4-bit threshold t.
REQ-016 Stage 2 SHALL register the quantized RGB and forward the syncs and visible.
REQ-017 Threshold t = M[yi][xi], where M rows are {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
REQ-018 Index xi = (position_x[1:0] + o) mod 4 and yi = (position_y[1:0] + o) mod 4.
REQ-019 Offset o = frame[1:0] in mode 2; o = 0 in every other mode.
REQ-020 Per channel with 4-bit value v: s = 3*v + (v>>2) as 6-bit unsigned, range 0..48; q = s[5:4]; rem = s[3:0].
REQ-021 Modes 1 and 2 SHALL output min(3, q + (rem > t)).
REQ-022 Mode 0 SHALL output v[3:2].
REQ-023 Mode 3 SHALL output 0 on all channels while syncs and visible still pass through.
REQ-024 When the delayed visible is 0, r/g/b SHALL be 0 regardless of mode.
REQ-025 The active mode (mode_q) SHALL update from the mode input only on a vsync_in 0->1 transition, detected against the previous-cycle vsync_in.
REQ-026 mode_q SHALL hold otherwise, so a mode change never takes effect mid-frame.
REQ-027 A mode change coinciding with the vsync_in rising edge SHALL be captured.
REQ-028 mode_q SHALL apply to the pixel entering stage 1 on the following cycle.
REQ-029 mod-4 wrap: xi and yi SHALL wrap with 2-bit overflow discarded; e.g. x[1:0]=3 with o=2 gives xi=1.
REQ-030 v=15 SHALL yield 3 and v=0 SHALL yield 0 for every t.

Reset
REQ-031 On rst, all pipeline registers SHALL load hsync=1, vsync=1, visible=0, r=g=b=0.
REQ-032 On rst, mode_q SHALL load 0 and the previous-vsync register SHALL load 1.
REQ-033 rst asserted mid-frame SHALL force the reset values on the outputs at the next clock edge.
REQ-034 After rst deasserts, the first input sample SHALL reach the outputs 2 cycles later; the outputs hold reset values until then.

Structure
REQ-035 Shared package vga_pkg SHALL hold the Bayer matrix constant, the mode enum (TRUNC, ORDERED, TEMPORAL, BLANK) and the channel widths 4 and 2.
REQ-036 Sub-module dither_quant SHALL implement the combinational single-channel v,t -> 2-bit quantizer and be instantiated three times.

Verification
REQ-037 Mode 1, x=0, y=0 (t=0), r_in=8, visible=1 -> r=2 two cycles later.
REQ-038 Mode 1, x=0, y=3 (t=15), r_in=8 -> r=1; mode 0, r_in=8 -> r=2; r_in=15 at all 16 (x,y) -> 3.
REQ-039 Mode 2, frame[1:0]=1, x=3, y=0 -> xi=0, yi=1, t=12; g_in=8 (rem 10) -> g=1.
REQ-040 mode changed 0->3 mid-frame -> output unchanged until the vsync_in rising edge, then r=g=b=0 while hsync/vsync still toggle with a 2-cycle delay.
REQ-041 visible_in=0 with r_in=15 -> r=0.
REQ-042 rst pulsed mid-line -> next cycle hsync=vsync=1 and rgb=0; first post-reset pixel appears at output exactly 2 cycles after rst falls.
